// File: rtl/axi_read_responder.sv
// axi_read_responder: in-order AXI read slave with fixed access latency and address-pattern data.
module axi_read_responder #(
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int LOG_REQ_QUEUE        = 2,
  parameter int LATENCY              = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  s_ar_valid,
  output logic                                  s_ar_ready,
  input  logic [BURST_LEN_WIDTH-1:0]            s_ar_len,
  input  logic [ADDR_BITS-1:0]                  s_ar_addr,
  input  logic [TID_WIDTH-1:0]                  s_ar_id,
  output logic                                  s_r_valid,
  input  logic                                  s_r_ready,
  output logic                                  s_r_last,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  s_r_data,
  output logic [TID_WIDTH-1:0]                  s_r_id,
  output logic [LOG_REQ_QUEUE:0]                reqCnt,
  output logic                                  busy
);
  localparam int DATA_BITS = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int REP = DATA_BITS / ADDR_BITS;
  localparam int DEPTH = 1 << LOG_REQ_QUEUE;
  localparam logic [7:0] LAT = 8'(LATENCY);
  typedef enum logic {IDLE, BURST} state_t;
  state_t                     state_q;
  logic [BURST_LEN_WIDTH-1:0] beat_q;
  logic [LOG_REQ_QUEUE-1:0]   head_q, tail_q, nxt;
  logic [LOG_REQ_QUEUE:0]     count_q;
  logic [ADDR_BITS-1:0]       addr_q [DEPTH];
  logic [BURST_LEN_WIDTH-1:0] len_q [DEPTH];
  logic [TID_WIDTH-1:0]       id_q [DEPTH];
  logic [7:0]                 age_q [DEPTH];
  logic [DEPTH-1:0]           vld_q;
  logic                       push, pop, last, in_burst, head_ok, next_ok;
  logic [ADDR_BITS-1:0]       beat_addr;
  assign s_ar_ready = ~reset & (count_q != (LOG_REQ_QUEUE+1)'(DEPTH));
  assign push       = s_ar_valid & s_ar_ready;
  assign in_burst   = state_q == BURST;
  assign nxt        = head_q + LOG_REQ_QUEUE'(1);
  assign head_ok    = vld_q[head_q] & (age_q[head_q] >= LAT);
  assign next_ok    = vld_q[nxt] & (age_q[nxt] >= LAT);
  assign last       = beat_q == len_q[head_q];
  assign pop        = in_burst & s_r_ready & last;
  assign beat_addr  = addr_q[head_q] + (ADDR_BITS'(beat_q) << LOG_BLOCK_DATA_BYTES);
  assign s_r_valid  = in_burst;
  assign s_r_last   = in_burst & last;
  assign s_r_data   = in_burst ? {REP{beat_addr}} : '0;
  assign s_r_id     = in_burst ? id_q[head_q] : '0;
  assign reqCnt     = count_q;
  assign busy       = (count_q != '0) | in_burst;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        len_q[i]  <= '0;
        id_q[i]   <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (vld_q[i] && age_q[i] < LAT) age_q[i] <= age_q[i] + 8'd1;
      if (push) begin
        addr_q[tail_q] <= s_ar_addr;
        len_q[tail_q]  <= s_ar_len;
        id_q[tail_q]   <= s_ar_id;
        age_q[tail_q]  <= 8'd0;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + LOG_REQ_QUEUE'(1);
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= nxt;
      end
      count_q <= count_q + (LOG_REQ_QUEUE+1)'(push) - (LOG_REQ_QUEUE+1)'(pop);
      // on the last beat, chain straight into the next burst if it is already eligible
      if (!in_burst) begin
        beat_q  <= '0;
        state_q <= head_ok ? BURST : IDLE;
      end else if (s_r_ready) begin
        beat_q  <= last ? '0 : beat_q + BURST_LEN_WIDTH'(1);
        state_q <= (last && !next_ok) ? IDLE : BURST;
      end
    end
  end
endmodule

// File: doc/axi_read_responder.md
# axi_read_responder

Memory-side AXI read responder: the slave end of the AR/R read path that the prefetcher's master port drives. It accepts AR requests into an in-order request queue and applies a fixed access latency to each one. It then returns each burst on R with the request's ID and a deterministic address-derived data pattern. It serves as the DDR stand-in for prefetcher system benches and as a reusable read-slave model.

## Interface
Parameters:
- ADDR_BITS, 64, address width
- BURST_LEN_WIDTH, 8, AR len width (len = beats-1)
- TID_WIDTH, 8, transaction ID width
- LOG_BLOCK_DATA_BYTES, 6, log2 bytes per beat; BLOCK_DATA_SIZE_BITS = 8<<LOG_BLOCK_DATA_BYTES, must be a multiple of ADDR_BITS
- LOG_REQ_QUEUE, 2, log2 request queue depth (depth 4)
- LATENCY, 4, minimum cycles a request ages in the queue before its burst may start (0..255)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- s_ar_valid  in  1  request valid
- s_ar_ready  out  1  request accepted when valid&ready
- s_ar_len  in  BURST_LEN_WIDTH  beats-1
- s_ar_addr  in  ADDR_BITS  first-beat byte address
- s_ar_id  in  TID_WIDTH  request ID
- s_r_valid  out  1  data beat valid
- s_r_ready  in  1  beat consumed when valid&ready
- s_r_last  out  1  final beat of burst
- s_r_data  out  BLOCK_DATA_SIZE_BITS  beat data
- s_r_id  out  TID_WIDTH  ID of current burst
- reqCnt  out  LOG_REQ_QUEUE+1  queued requests, including the active one
- busy  out  1  reqCnt!=0 or state BURST

## Operation
- Queue: circular FIFO of {addr, len, id, age}, with head/tail pointers and a count. Push on AR handshake; pop on the handshake of the last beat of the head burst.
- s_ar_ready = ~reset & (count != depth). There is no bypass: when full, ready stays 0 even in a cycle that pops.
- Age: 0 on push. Every valid entry increments its age each cycle, saturating at LATENCY. An entry is eligible when age >= LATENCY.
- FSM with states IDLE and BURST:
  - IDLE: if the head is valid and eligible, go to BURST with beat=0.
  - BURST: s_r_valid=1.
    - On handshake with beat != head.len: beat++.
    - On handshake with beat == head.len: pop the head. If the next entry is valid and eligible in the same cycle, stay in BURST with beat=0 (no bubble). Otherwise go to IDLE.
- Outputs in BURST, all driven from the head entry:
  - beatAddr = head.addr + (beat << LOG_BLOCK_DATA_BYTES), modulo 2^ADDR_BITS. No alignment is applied.
  - s_r_data = beatAddr replicated BLOCK_DATA_SIZE_BITS/ADDR_BITS times.
  - s_r_id = head.id.
  - s_r_last = (beat == head.len).
- Outputs in IDLE: s_r_valid=0, s_r_last=0, s_r_data=0, s_r_id=0.
- Beat counter width is BURST_LEN_WIDTH. len=0 gives a single beat with last=1.
- Bursts are returned strictly in acceptance order, regardless of ID.

## Timing
- Reset values: queue empty, count=0, state IDLE, beat=0, s_r_valid=0, s_r_last=0, s_r_data=0, s_r_id=0, reqCnt=0, busy=0, s_ar_ready=0 while reset is high.
- Reset asserted mid-burst: the burst is abandoned immediately (asynchronously), all queued requests are discarded, and no partial beats are emitted after reset releases.
- Isolated request with AR handshake in cycle k into an empty responder:
  - entry present in cycle k+1 with age 0;
  - eligible in cycle k+1+LATENCY;
  - first s_r_valid in cycle k+2+LATENCY.
- Beat throughput: one beat per cycle while s_r_ready=1.
- While s_r_valid=1 and s_r_ready=0, s_r_data, s_r_id and s_r_last hold stable until the handshake.
- Push and pop in the same cycle: count is unchanged and both operations take effect.
- reqCnt reflects the registered count: it rises the cycle after a push and falls the cycle after the last-beat pop.

## Test plan
- LATENCY=4; AR handshake in cycle 0 with addr=0x1000, len=3, id=5; s_r_ready=1 → s_r_valid rises in cycle 6; beats carry 0x1000, 0x1040, 0x1080, 0x10C0, each replicated 8×; s_r_last only on the 4th beat; s_r_id=5; busy falls in cycle 10.
- Back-to-back: id=1/len=1 then id=2/len=0 accepted in consecutive cycles, s_r_ready=1 → three consecutive beats with no bubble; ids 1,1,2; last on beats 2 and 3.
- Full queue: s_r_ready=0 with 5 requests offered → 4 accepted; reqCnt=4; s_ar_ready=0; 5th request held. Raise s_r_ready → s_ar_ready returns to 1 the cycle after the first burst's last-beat pop, and the 5th request is accepted.
- Backpressure: s_r_ready toggles 1,0,0,1 during a len=3 burst → valid stays high; data/id/last are stable across stalls; exactly 4 handshakes occur.
- Wrap: addr=0xFFFF_FFFF_FFFF_FFC0, len=1 → beat data 0xFFFF_FFFF_FFFF_FFC0 then 0x0000_0000_0000_0000.
- Reset pulse at beat 2 of a len=7 burst with 2 requests queued → s_r_valid=0 and reqCnt=0 immediately. After release, a new request (addr=0x40, len=0, id=3) returns one beat with data 0x40 at LATENCY+2 cycles.
